// File: rtl/fifo_write_ctrl.sv
// Write-domain half of an async FIFO: binary/Gray write pointers, RAM write strobe,
// read-pointer synchroniser and the full / almost_full / level / overflow flags.
module fifo_write_ctrl #(
  parameter int PTR_WIDTH    = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AF_THRESHOLD = 2
) (
  input  logic                 w_clk,
  input  logic                 wresetn,
  input  logic                 wr_enable,
  input  logic                 flush,
  input  logic [PTR_WIDTH:0]   rd_ptr_gray,
  output logic                 fifo_wr_enable,
  output logic [PTR_WIDTH-1:0] wr_addr,
  output logic [PTR_WIDTH:0]   write_ptr,
  output logic [PTR_WIDTH:0]   write_ptr_gray,
  output logic                 full,
  output logic                 almost_full,
  output logic [PTR_WIDTH:0]   wr_level,
  output logic                 overflow
);

  localparam int                 DEPTH    = 1 << PTR_WIDTH;
  localparam logic [PTR_WIDTH:0] DEPTH_V  = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] AF_LEVEL = (PTR_WIDTH+1)'(DEPTH - AF_THRESHOLD);

  logic [PTR_WIDTH:0] rg_sync_q [SYNC_STAGES];
  logic [PTR_WIDTH:0] rptr_sync;
  logic [PTR_WIDTH:0] wptr_next;
  logic [PTR_WIDTH:0] level_next;

  function automatic logic [PTR_WIDTH:0] gray2bin(input logic [PTR_WIDTH:0] g);
    logic [PTR_WIDTH:0] b;
    b[PTR_WIDTH] = g[PTR_WIDTH];
    for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // The strobe is gated by reset so no RAM write can slip out while wresetn is low.
  assign fifo_wr_enable = wresetn & wr_enable & ~full & ~flush;
  assign wr_addr        = write_ptr[PTR_WIDTH-1:0];
  assign wptr_next      = write_ptr + {{PTR_WIDTH{1'b0}}, fifo_wr_enable};
  assign rptr_sync      = gray2bin(rg_sync_q[SYNC_STAGES-1]);
  assign level_next     = wptr_next - rptr_sync;

  always_ff @(posedge w_clk or negedge wresetn) begin
    if (!wresetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) rg_sync_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < SYNC_STAGES; i++) rg_sync_q[i] <= '0;
    end else begin
      rg_sync_q[0] <= rd_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) rg_sync_q[i] <= rg_sync_q[i-1];
    end
  end

  // Flags come from the lagging synchronised read pointer, so they can only err towards full.
  always_ff @(posedge w_clk or negedge wresetn) begin
    if (!wresetn) begin
      write_ptr      <= '0;
      write_ptr_gray <= '0;
      wr_level       <= '0;
      full           <= 1'b0;
      almost_full    <= 1'b0;
      overflow       <= 1'b0;
    end else if (flush) begin
      write_ptr      <= '0;
      write_ptr_gray <= '0;
      wr_level       <= '0;
      full           <= 1'b0;
      almost_full    <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      write_ptr      <= wptr_next;
      write_ptr_gray <= wptr_next ^ (wptr_next >> 1);
      wr_level       <= level_next;
      full           <= (level_next == DEPTH_V);
      almost_full    <= (level_next >= AF_LEVEL);
      if (wr_enable && full) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Directed bench for fifo_write_ctrl: driver pushes expected output snapshots tagged
// with a cycle number; a negedge monitor pops and compares them.
module tb_fifo_write_ctrl;

  logic       w_clk = 1'b0;
  logic       wresetn;
  logic       wr_enable;
  logic       flush;
  logic [4:0] rd_ptr_gray;
  logic       fifo_wr_enable;
  logic [3:0] wr_addr;
  logic [4:0] write_ptr;
  logic [4:0] write_ptr_gray;
  logic       full;
  logic       almost_full;
  logic [4:0] wr_level;
  logic       overflow;

  fifo_write_ctrl #(.PTR_WIDTH(4), .SYNC_STAGES(2), .AF_THRESHOLD(2)) dut (
    .w_clk(w_clk), .wresetn(wresetn), .wr_enable(wr_enable), .flush(flush),
    .rd_ptr_gray(rd_ptr_gray), .fifo_wr_enable(fifo_wr_enable), .wr_addr(wr_addr),
    .write_ptr(write_ptr), .write_ptr_gray(write_ptr_gray), .full(full),
    .almost_full(almost_full), .wr_level(wr_level), .overflow(overflow)
  );

  // clock / cycle counter
  always #5 w_clk = ~w_clk;
  int cyc = 0;
  always @(posedge w_clk) cyc <= cyc + 1;

  // scoreboard: {fwe, ptr, gray, level, full, af, ovf}
  logic [18:0] exp_q[$];
  int          cyc_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [4:0] g5(input int v);
    logic [4:0] b;
    b = 5'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic step(input logic we, input logic fl, input logic [4:0] rg);
    @(posedge w_clk);
    #1;
    wr_enable   = we;
    flush       = fl;
    rd_ptr_gray = rg;
  endtask

  task automatic chk(input logic fwe, input logic [4:0] p, input logic [4:0] g,
                     input logic [4:0] l, input logic f, input logic af,
                     input logic ov, input string nm);
    exp_q.push_back({fwe, p, g, l, f, af, ov});
    cyc_q.push_back(cyc);
    name_q.push_back(nm);
  endtask

  // monitor
  always @(negedge w_clk) begin
    logic [18:0] act, ex;
    string nm;
    act = {fifo_wr_enable, write_ptr, write_ptr_gray, wr_level, full, almost_full, overflow};
    while (exp_q.size() > 0 && cyc_q[0] <= cyc) begin
      ex = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (cyc_q.pop_front() != cyc) begin
        errors++;
        $display("FAIL %s: expectation not sampled in its cycle (now %0d)", nm, cyc);
      end else if (act !== ex || wr_addr !== write_ptr[3:0]) begin
        errors++;
        $display("FAIL %s cyc=%0d: got fwe=%b ptr=%h gray=%h lvl=%0d full=%b af=%b ovf=%b addr=%h, exp fwe=%b ptr=%h gray=%h lvl=%0d full=%b af=%b ovf=%b",
                 nm, cyc, act[18], act[17:13], act[12:8], act[7:3], act[2], act[1], act[0], wr_addr,
                 ex[18], ex[17:13], ex[12:8], ex[7:3], ex[2], ex[1], ex[0]);
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: time limit reached, %0d expectations pending", exp_q.size());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int p, r;
    wresetn = 1'b0; wr_enable = 1'b1; flush = 1'b0; rd_ptr_gray = '0;

    // reset: strobe blocked and every output cleared
    step(1, 0, 0);
    chk(0, 0, 0, 0, 0, 0, 0, "in_reset");
    step(0, 0, 0); wresetn = 1'b1;
    chk(0, 0, 0, 0, 0, 0, 0, "reset_release");

    // fill to full; first write cycle checks fifo_wr_enable follows wr_enable
    for (int i = 1; i <= 16; i++) begin
      step(1, 0, 0);
      chk(1, 5'(i-1), g5(i-1), 5'(i-1), 0, (i-1) >= 14, 0, "fill");
    end

    // writes blocked while full, overflow sticky
    step(1, 0, 0); chk(0, 5'd16, 5'h18, 5'd16, 1, 1, 0, "full_reached");
    step(1, 0, 0); chk(0, 5'd16, 5'h18, 5'd16, 1, 1, 1, "overflow_set");
    step(0, 0, 0); chk(0, 5'd16, 5'h18, 5'd16, 1, 1, 1, "overflow_sticky");

    // one read seen after two sync edges plus one flag edge
    step(0, 0, 5'h01); chk(0, 5'd16, 5'h18, 5'd16, 1, 1, 1, "rd_move_e0");
    step(0, 0, 5'h01); chk(0, 5'd16, 5'h18, 5'd16, 1, 1, 1, "rd_move_e1");
    step(0, 0, 5'h01); chk(0, 5'd16, 5'h18, 5'd16, 1, 1, 1, "rd_move_e2");
    step(0, 0, 5'h01); chk(0, 5'd16, 5'h18, 5'd15, 0, 1, 1, "full_cleared");

    // flush (read side also returns to 0)
    step(0, 1, 0); chk(0, 5'd16, 5'h18, 5'd15, 0, 1, 1, "pre_flush");

    // streaming 40 writes, read pointer driven 2 behind write_ptr
    for (int c = 1; c <= 40; c++) begin
      p = (c - 1) % 32;
      r = (c > 3) ? c - 3 : 0;
      step(1, 0, g5(r));
      chk(1, 5'(p), g5(p), 5'((c - 1) - ((c > 6) ? c - 6 : 0)), 0, 0, 0, "stream");
    end
    for (int c = 41; c <= 45; c++) step(0, 0, g5(6));
    chk(0, 5'd8, 5'h0c, 5'd2, 0, 0, 0, "stream_settled");

    // climb to level 9, then flush with wr_enable held high
    for (int d = 1; d <= 7; d++) begin
      step(1, 0, g5(6));
      chk(1, 5'(8 + d - 1), g5(8 + d - 1), 5'(d + 1), 0, 0, 0, "climb");
    end
    step(1, 1, 0); chk(0, 5'd15, 5'h08, 5'd9, 0, 0, 0, "flush_cycle");
    step(1, 0, 0); chk(1, 0, 0, 0, 0, 0, 0, "after_flush");
    step(1, 0, 0); chk(1, 5'd1, 5'd1, 5'd1, 0, 0, 0, "burst_1");

    // asynchronous reset mid-burst
    step(1, 0, 0); wresetn = 1'b0;
    #1;
    chk(0, 0, 0, 0, 0, 0, 0, "reset_mid_burst");
    step(1, 0, 0); wresetn = 1'b1;
    chk(1, 0, 0, 0, 0, 0, 0, "reset_mid_release");
    step(0, 0, 0); chk(0, 5'd1, 5'd1, 5'd1, 0, 0, 0, "post_reset_write");

    repeat (3) @(negedge w_clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations never compared", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
